// File: rtl/haraka_sponge_pkg.sv
// Shared types and constants for the Haraka-S sponge controller.
// Provides the FSM encoding, default padding bytes and the rate-lane bit-offset helper.
package haraka_sponge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ABSORB  = 3'd1,
        PAD     = 3'd2,
        PERM    = 3'd3,
        SQUEEZE = 3'd4
    } sponge_state_e;

    localparam logic [7:0] DOMAIN_PAD_DEF = 8'h1F;
    localparam logic [7:0] FINAL_PAD_DEF  = 8'h80;

    // Rate byte i occupies the top of the state, lane 0 in the most significant byte.
    function automatic int unsigned lane_hi(input int unsigned i, input int unsigned state_bits = 512);
        return state_bits - 1 - 8 * i;
    endfunction

endpackage

// File: rtl/haraka_rate_lane.sv
// Combinational byte-lane access to the rate region: XOR a byte into lane idx,
// apply SHAKE-style padding, and select lane idx for the squeeze output.
module haraka_rate_lane
    import haraka_sponge_pkg::*;
#(
    parameter int         STATE_BITS = 512,
    parameter int         RATE_BYTES = 32,
    parameter int         IDX_W      = 6,
    parameter logic [7:0] DOMAIN_PAD = DOMAIN_PAD_DEF,
    parameter logic [7:0] FINAL_PAD  = FINAL_PAD_DEF
) (
    input  logic [STATE_BITS-1:0] state,
    input  logic [IDX_W-1:0]      idx,
    input  logic [7:0]            data,
    input  logic                  xor_en,
    input  logic                  pad_en,
    output logic [STATE_BITS-1:0] state_nxt,
    output logic [7:0]            sel_byte
);

    always_comb begin
        state_nxt = state;
        sel_byte  = '0;
        for (int i = 0; i < RATE_BYTES; i++) begin
            if (int'(idx) == i) begin
                sel_byte = state[lane_hi(i, STATE_BITS) -: 8];
                if (xor_en)
                    state_nxt[lane_hi(i, STATE_BITS) -: 8] = state_nxt[lane_hi(i, STATE_BITS) -: 8] ^ data;
                if (pad_en)
                    state_nxt[lane_hi(i, STATE_BITS) -: 8] = state_nxt[lane_hi(i, STATE_BITS) -: 8] ^ DOMAIN_PAD;
            end
        end
        // Applied after the domain byte so both land when idx is the last lane.
        if (pad_en)
            state_nxt[lane_hi(RATE_BYTES - 1, STATE_BITS) -: 8] =
                state_nxt[lane_hi(RATE_BYTES - 1, STATE_BITS) -: 8] ^ FINAL_PAD;
    end

endmodule

// File: rtl/haraka_sponge_ctrl.sv
// Sponge controller: absorbs a byte stream, drives an external permutation and squeezes digest bytes.
// Define HARAKA_SPONGE_ABORT_EN to add the abort input that returns the controller to IDLE.
module haraka_sponge_ctrl
    import haraka_sponge_pkg::*;
#(
    parameter int         STATE_BITS = 512,
    parameter int         RATE_BYTES = 32,
    parameter int         DLEN_W     = 32,
    parameter logic [7:0] DOMAIN_PAD = DOMAIN_PAD_DEF,
    parameter logic [7:0] FINAL_PAD  = FINAL_PAD_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic [DLEN_W-1:0]     digest_len,
    output logic                  perm_start,
    output logic [STATE_BITS-1:0] perm_state_out,
    input  logic                  perm_done,
    input  logic [STATE_BITS-1:0] perm_state_in,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic                  out_last,
    input  logic                  out_ready,
`ifdef HARAKA_SPONGE_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy,
    output logic                  done
);

    localparam int              IDX_W    = $clog2(RATE_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_BYTES - 1);

    sponge_state_e           fsm, fsm_nxt, ret_st, ret_nxt;
    logic [STATE_BITS-1:0]   state, state_nxt, lane_base, lane_out;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [DLEN_W-1:0]       remaining, rem_nxt;
    logic [7:0]              sel_byte;
    logic                    perm_first, armed;
    logic                    accept, emit, abort_i;

`ifdef HARAKA_SPONGE_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign accept         = in_valid && in_ready;
    assign emit           = out_valid && out_ready;
    assign lane_base      = (fsm == IDLE) ? '0 : state;
    assign perm_state_out = state;

    haraka_rate_lane #(
        .STATE_BITS (STATE_BITS),
        .RATE_BYTES (RATE_BYTES),
        .IDX_W      (IDX_W),
        .DOMAIN_PAD (DOMAIN_PAD),
        .FINAL_PAD  (FINAL_PAD)
    ) u_rate_lane (
        .state     (lane_base),
        .idx       (idx),
        .data      (in_data),
        .xor_en    (accept),
        .pad_en    (fsm == PAD),
        .state_nxt (lane_out),
        .sel_byte  (sel_byte)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            fsm <= IDLE;
        else
            fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt   = fsm;
        ret_nxt   = ret_st;
        idx_nxt   = idx;
        rem_nxt   = remaining;
        state_nxt = state;
        case (fsm)
            IDLE: begin
                if (accept) begin
                    state_nxt = lane_out;
                    rem_nxt   = digest_len;
                    idx_nxt   = IDX_W'(1);
                    fsm_nxt   = in_last ? PAD : ABSORB;
                end
            end
            ABSORB: begin
                if (accept) begin
                    state_nxt = lane_out;
                    if (idx == LAST_IDX) begin
                        idx_nxt = '0;
                        fsm_nxt = PERM;
                        ret_nxt = in_last ? PAD : ABSORB;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                        if (in_last)
                            fsm_nxt = PAD;
                    end
                end
            end
            PAD: begin
                state_nxt = lane_out;
                idx_nxt   = '0;
                fsm_nxt   = PERM;
                ret_nxt   = SQUEEZE;
            end
            PERM: begin
                if (perm_done) begin
                    state_nxt = perm_state_in;
                    fsm_nxt   = ret_st;
                end
            end
            SQUEEZE: begin
                if (remaining == '0) begin
                    idx_nxt = '0;
                    fsm_nxt = IDLE;
                end else if (emit) begin
                    rem_nxt = remaining - DLEN_W'(1);
                    if (idx == LAST_IDX) begin
                        // Block exhausted: only re-permute if more bytes are still owed.
                        idx_nxt = '0;
                        ret_nxt = SQUEEZE;
                        if (remaining != DLEN_W'(1))
                            fsm_nxt = PERM;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: fsm_nxt = IDLE;
        endcase
        if (abort_i) begin
            fsm_nxt   = IDLE;
            ret_nxt   = IDLE;
            idx_nxt   = '0;
            rem_nxt   = '0;
            state_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= '0;
            idx        <= '0;
            remaining  <= '0;
            ret_st     <= IDLE;
            perm_first <= 1'b0;
            armed      <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            remaining  <= rem_nxt;
            ret_st     <= ret_nxt;
            perm_first <= (fsm_nxt == PERM) && (fsm != PERM);
            armed      <= 1'b1;
        end
    end

    always_comb begin
        in_ready   = armed && ((fsm == IDLE) || (fsm == ABSORB)) && !abort_i;
        perm_start = (fsm == PERM) && perm_first && !abort_i;
        out_valid  = (fsm == SQUEEZE) && (remaining != '0) && !abort_i;
        out_data   = out_valid ? sel_byte : 8'h00;
        out_last   = out_valid && (remaining == DLEN_W'(1));
        busy       = (fsm != IDLE);
        done       = (fsm == SQUEEZE) && (remaining == '0) && !abort_i;
    end

endmodule

// File: tb/tb_haraka_sponge_ctrl.sv
// Self-checking bench for haraka_sponge_ctrl with an identity permutation stub and a digest scoreboard.
// Abort scenario is compiled when HARAKA_SPONGE_ABORT_EN is defined.
module tb_haraka_sponge_ctrl;

    localparam int SB = 512;
    localparam int RB = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] digest_len;
    logic          perm_start;
    logic [SB-1:0] perm_state_out;
    logic          perm_done;
    logic [SB-1:0] perm_state_in;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_last;
    logic          out_ready;
    logic          busy;
    logic          done;
`ifdef HARAKA_SPONGE_ABORT_EN
    logic          abort;
`endif

    always #5 clk = ~clk;

    haraka_sponge_ctrl #(
        .STATE_BITS (SB),
        .RATE_BYTES (RB),
        .DLEN_W     (DW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .digest_len     (digest_len),
        .perm_start     (perm_start),
        .perm_state_out (perm_state_out),
        .perm_done      (perm_done),
        .perm_state_in  (perm_state_in),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_ready      (out_ready),
`ifdef HARAKA_SPONGE_ABORT_EN
        .abort          (abort),
`endif
        .busy           (busy),
        .done           (done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int start_cnt, done_cnt, ov_cnt, hs_cnt, cyc, last_cyc, done_cyc;
    logic [8:0]    exp_q[$];
    logic [SB-1:0] st_q[$];
    logic [8:0]    exp_e;
    bit            toggle_rdy = 1'b0;
    logic          prev_stall = 1'b0;
    logic [7:0]    prev_data;
    logic          prev_last;

    // Identity permutation: done arrives a few cycles after start, echoing the captured state.
    logic          stub_pend;
    int            stub_cnt;
    logic [SB-1:0] stub_cap;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perm_done     <= 1'b0;
            perm_state_in <= '0;
            stub_pend     <= 1'b0;
            stub_cnt      <= 0;
            stub_cap      <= '0;
        end else begin
            perm_done <= 1'b0;
            if (perm_start) begin
                stub_pend <= 1'b1;
                stub_cnt  <= 4;
                stub_cap  <= perm_state_out;
            end else if (stub_pend) begin
                if (stub_cnt == 1) begin
                    perm_done     <= 1'b1;
                    perm_state_in <= stub_cap;
                    stub_pend     <= 1'b0;
                end
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (toggle_rdy) out_ready = ~out_ready;
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            cyc++;
            if (perm_start) begin
                start_cnt++;
                st_q.push_back(perm_state_out);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid) ov_cnt++;
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                             out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && out_ready) begin
                hs_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL digest_extra: got d=%h l=%b, required no byte", out_data, out_last);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({out_last, out_data} !== exp_e) begin
                        n_err++;
                        $display("FAIL digest_byte %0d: got l=%b d=%h, required l=%b d=%h",
                                 hs_cnt, out_last, out_data, exp_e[8], exp_e[7:0]);
                    end
                end
                if (out_last) last_cyc = cyc;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_counts();
        start_cnt = 0; done_cnt = 0; ov_cnt = 0; hs_cnt = 0;
        last_cyc = -100; done_cyc = -200;
        st_q.delete();
        exp_q.delete();
    endtask

    // Expected digest with an identity permutation: the padded rate block repeated.
    task automatic push_expected(input logic [7:0] msg[$], input int dlen);
        logic [7:0] rate[RB];
        int p;
        for (int i = 0; i < RB; i++) rate[i] = 8'h00;
        for (int i = 0; i < msg.size(); i++) rate[i % RB] ^= msg[i];
        p = msg.size() % RB;
        rate[p]    ^= 8'h1F;
        rate[RB-1] ^= 8'h80;
        for (int j = 0; j < dlen; j++) exp_q.push_back({(j == dlen - 1), rate[j % RB]});
    endtask

    task automatic send_msg(input logic [7:0] msg[$], input logic [DW-1:0] dlen);
        int w;
        for (int i = 0; i < msg.size(); i++) begin
            in_valid   = 1'b1;
            in_data    = msg[i];
            in_last    = (i == msg.size() - 1);
            digest_len = dlen;
            w = 0;
            @(negedge clk);
            while (in_ready !== 1'b1 && w < 500) begin
                @(negedge clk);
                w++;
            end
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL in_ready_wait: byte %0d got in_ready=%b, required 1", i, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int w = 0;
        while (done_cnt == 0 && w < budget) begin
            @(posedge clk);
            w++;
        end
        n_cmp++;
        if (done_cnt == 0) begin
            n_err++;
            $display("FAIL done_timeout: got no done in %0d cycles, required a done pulse", budget);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        digest_len = '0; out_ready = 1'b1;
`ifdef HARAKA_SPONGE_ABORT_EN
        abort = 1'b0;
`endif
        clear_counts();
        #1;
        n_cmp++;
        if ({in_ready, perm_start, out_valid, out_last, busy, done} !== 6'b0 ||
            out_data !== 8'h00 || perm_state_out !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b ps=%b ov=%b ol=%b busy=%b done=%b od=%h, required all 0",
                     in_ready, perm_start, out_valid, out_last, busy, done, out_data);
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_abc();
        logic [7:0]    m[$];
        logic [SB-1:0] exp_s;
        clear_counts();
        m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
        exp_s = '0;
        exp_s[SB-1 -: 32]      = 32'h6162631F;
        exp_s[SB-1-8*31 -: 8] = 8'h80;
        send_msg(m, '0);
        wait_done(200);
        n_cmp++;
        if (start_cnt !== 1) begin
            n_err++;
            $display("FAIL abc_perm_count: got %0d, required 1", start_cnt);
        end
        n_cmp++;
        if (st_q.size() == 0 || st_q[0] !== exp_s) begin
            n_err++;
            $display("FAIL abc_perm_state: got %h, required %h", (st_q.size() > 0) ? st_q[0] : '0, exp_s);
        end
        n_cmp++;
        if (ov_cnt !== 0 || done_cnt !== 1) begin
            n_err++;
            $display("FAIL abc_outputs: got out_valid cycles=%0d done pulses=%0d, required 0 1", ov_cnt, done_cnt);
        end
    endtask

    task automatic test_full_block();
        logic [7:0]    m[$];
        logic [SB-1:0] exp0, exp1;
        clear_counts();
        exp0 = '0;
        for (int i = 0; i < RB; i++) begin
            m.push_back(8'(i));
            exp0[SB-1-8*i -: 8] = 8'(i);
        end
        exp1 = exp0;
        exp1[SB-1 -: 8]        = 8'h1F;
        exp1[SB-1-8*31 -: 8]   = 8'h9F;
        send_msg(m, '0);
        wait_done(300);
        n_cmp++;
        if (start_cnt !== 2) begin
            n_err++;
            $display("FAIL full_perm_count: got %0d, required 2", start_cnt);
        end
        n_cmp++;
        if (st_q.size() < 1 || st_q[0] !== exp0) begin
            n_err++;
            $display("FAIL full_first_state: got %h, required %h", (st_q.size() > 0) ? st_q[0] : '0, exp0);
        end
        n_cmp++;
        if (st_q.size() < 2 || st_q[1] !== exp1) begin
            n_err++;
            $display("FAIL full_padded_state: got %h, required %h", (st_q.size() > 1) ? st_q[1] : '0, exp1);
        end
    endtask

    task automatic test_squeeze(input bit stall);
        logic [7:0] m[$];
        clear_counts();
        m.push_back(8'hAA);
        push_expected(m, 40);
        out_ready  = 1'b1;
        toggle_rdy = stall;
        send_msg(m, 40);
        wait_done(2000);
        toggle_rdy = 1'b0;
        out_ready  = 1'b1;
        n_cmp++;
        if (hs_cnt !== 40 || exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL squeeze_count stall=%0d: got %0d bytes (%0d unmatched), required 40 (0)",
                     stall, hs_cnt, exp_q.size());
        end
        n_cmp++;
        if (start_cnt !== 2) begin
            n_err++;
            $display("FAIL squeeze_perm_count stall=%0d: got %0d, required 2", stall, start_cnt);
        end
        n_cmp++;
        if (done_cnt !== 1 || done_cyc !== last_cyc + 1) begin
            n_err++;
            $display("FAIL squeeze_done_timing stall=%0d: got done=%0d at cycle %0d (last at %0d), required 1 at last+1",
                     stall, done_cnt, done_cyc, last_cyc);
        end
    endtask

    task automatic test_reset_mid_squeeze();
        logic [7:0] m[$];
        int w = 0;
        clear_counts();
        m.push_back(8'hAA);
        push_expected(m, 40);
        out_ready = 1'b1;
        send_msg(m, 40);
        while (hs_cnt < 10 && w < 500) begin
            @(negedge clk); #1;
            w++;
        end
        n_cmp++;
        if (hs_cnt !== 10) begin
            n_err++;
            $display("FAIL mid_reset_reach: got %0d bytes, required 10", hs_cnt);
        end
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        n_cmp++;
        if ({in_ready, perm_start, out_valid, out_last, busy, done} !== 6'b0 ||
            out_data !== 8'h00 || perm_state_out !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got rdy=%b ps=%b ov=%b ol=%b busy=%b done=%b od=%h, required all 0",
                     in_ready, perm_start, out_valid, out_last, busy, done, out_data);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_ready: got %b, required 1", in_ready);
        end
        test_abc();
    endtask

`ifdef HARAKA_SPONGE_ABORT_EN
    task automatic test_abort();
        logic [7:0] m[$];
        int w = 0;
        clear_counts();
        m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
        send_msg(m, '0);
        while (start_cnt == 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || perm_start !== 1'b0 || perm_state_out !== '0) begin
            n_err++;
            $display("FAIL abort_idle: got busy=%b perm_start=%b, required 0 0 with cleared state", busy, perm_start);
        end
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (done_cnt !== 0 || busy !== 1'b0 || start_cnt !== 1) begin
            n_err++;
            $display("FAIL abort_late_done: got done=%0d busy=%b starts=%0d, required 0 0 1", done_cnt, busy, start_cnt);
        end
        test_abc();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_abc();
        test_full_block();
        test_squeeze(1'b0);
        test_squeeze(1'b1);
        test_reset_mid_squeeze();
`ifdef HARAKA_SPONGE_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
